// File: rtl/audio_rd_sched.sv
// rtl/audio_rd_sched.sv - horizontal-blanking burst read scheduler for the receive audio FIFO (optional AUDIO_SCHED_STATS_EN adds rd_words)
module audio_rd_sched #(
    parameter logic [11:0] HSTART     = 12'd1530,
    parameter int          BURST_LEN  = 32,
    parameter int          BURST_GAP  = 4,
    parameter int          MAX_BURSTS = 15
) (
    input  logic        fifo_clk,
    input  logic        sys_rst,
    input  logic [11:0] hcnt,
    input  logic [11:0] vcnt,
    input  logic        vde,
    input  logic        ax_empty,
    input  logic [11:0] ax_dout,
    output logic        ax_rd_en,
    output logic        burst_active,
    output logic [3:0]  burst_cnt,
    output logic        audio_on,
`ifdef AUDIO_SCHED_STATS_EN
    output logic [15:0] rd_words,
`endif
    output logic        underrun
);

    // One phase counter serves both BURST (0..BURST_LEN-1) and GAP (0..BURST_GAP-1).
    localparam int PH_W = $clog2(BURST_LEN);
    localparam logic [PH_W-1:0] BURST_LAST = PH_W'(BURST_LEN - 1);
    localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(BURST_GAP - 1);
    localparam logic [3:0]      MAX_B      = 4'(MAX_BURSTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic [3:0]      b_left_q, b_left_d;
    logic            init_q, init_d;
    logic            ck_q, ck_d;
    logic            audio_on_q, audio_on_d;
    logic            underrun_q, underrun_d;
    logic            req;
    logic            rd_en;
    logic            frame_start;
`ifdef AUDIO_SCHED_STATS_EN
    logic [15:0]     rd_cnt_q, rd_cnt_d;
    logic [15:0]     rd_words_q, rd_words_d;
`endif

    // Next-state, burst sequencing, presence/underrun bookkeeping.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        burst_cnt_d = burst_cnt_q;
        b_left_d    = b_left_q;
        init_d      = init_q | vde;
        ck_d        = ck_q;
        audio_on_d  = audio_on_q;
        underrun_d  = underrun_q;

        frame_start = (vcnt == 12'd0) && (hcnt == 12'd0);
        req         = (state_q == S_BURST);
        // vde gates the read combinationally so an abort never steals an active-video slot.
        rd_en       = req & ~ax_empty & ~vde;

        // Clear first so a same-cycle set (new frame's first event) wins.
        if (frame_start) begin
            audio_on_d = ck_q;
            ck_d       = 1'b0;
            underrun_d = 1'b0;
        end
        if (!ax_empty) begin
            ck_d = 1'b1;
        end
        if (req && ax_empty) begin
            underrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (init_q && !vde && !ax_empty && (hcnt == HSTART)) begin
                    state_d     = S_BURST;
                    phase_d     = '0;
                    burst_cnt_d = 4'd1;
                end
            end
            S_BURST: begin
                if (vde) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (phase_q == BURST_LAST) begin
                    state_d = S_GAP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_GAP: begin
                if (vde) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    // Last word of the burst arrives one cycle after its read.
                    if (phase_q == '0) begin
                        b_left_d = ax_dout[11:8];
                    end
                    if (phase_q == GAP_LAST) begin
                        phase_d = '0;
                        if ((b_left_d != 4'd0) && (burst_cnt_q < MAX_B) && !ax_empty) begin
                            state_d     = S_BURST;
                            burst_cnt_d = burst_cnt_q + 4'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

`ifdef AUDIO_SCHED_STATS_EN
    // Per-frame read-cycle count, saturating, published at the frame boundary.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        rd_words_d = rd_words_q;
        if (frame_start) begin
            rd_words_d = rd_cnt_q;
            rd_cnt_d   = 16'd0;
        end
        if (rd_en && (rd_cnt_d != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_d + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            rd_cnt_q   <= 16'd0;
            rd_words_q <= 16'd0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            rd_words_q <= rd_words_d;
        end
    end

    assign rd_words = rd_words_q;
`endif

    // State and bookkeeping registers; reset abandons any burst in progress.
    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            burst_cnt_q <= 4'd0;
            b_left_q    <= 4'd0;
            init_q      <= 1'b0;
            ck_q        <= 1'b0;
            audio_on_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            burst_cnt_q <= burst_cnt_d;
            b_left_q    <= b_left_d;
            init_q      <= init_d;
            ck_q        <= ck_d;
            audio_on_q  <= audio_on_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ax_rd_en     = rd_en;
    assign burst_active = (state_q != S_IDLE);
    assign burst_cnt    = burst_cnt_q;
    assign audio_on     = audio_on_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_rd_sched.sv
// tb/tb_audio_rd_sched.sv - scoreboard bench for audio_rd_sched (AUDIO_SCHED_STATS_EN also checks rd_words)
module tb_audio_rd_sched;

    localparam logic [11:0] HS = 12'd1530;

    logic        clk;
    logic        sys_rst;
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        vde;
    logic        ax_empty;
    logic [11:0] ax_dout;
    logic        ax_rd_en;
    logic        burst_active;
    logic [3:0]  burst_cnt;
    logic        audio_on;
    logic        underrun;
`ifdef AUDIO_SCHED_STATS_EN
    logic [15:0] rd_words;
`endif

    audio_rd_sched dut (
        .fifo_clk     (clk),
        .sys_rst      (sys_rst),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .vde          (vde),
        .ax_empty     (ax_empty),
        .ax_dout      (ax_dout),
        .ax_rd_en     (ax_rd_en),
        .burst_active (burst_active),
        .burst_cnt    (burst_cnt),
        .audio_on     (audio_on),
`ifdef AUDIO_SCHED_STATS_EN
        .rd_words     (rd_words),
`endif
        .underrun     (underrun)
    );

    typedef struct packed {
        int          cyc;
        int          tag;
        logic        rd;
        logic        act;
        logic [3:0]  bcnt;
        logic        und;
        logic        aon;
        logic        chkw;
        logic [15:0] w;
    } stat_t;

    int    exp_rd_q[$];
    stat_t stat_q[$];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rd_total = 0;
    int   rd_base = 0;
    int   fidx;
    int   c;
    logic done = 1'b0;
    logic flushed = 1'b0;
    logic [3:0] bl_tab [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: 1-cycle read latency; bits [11:8] give bursts remaining per 32-word block.
    always @(posedge clk) begin
        if (ax_rd_en) begin
            fidx = rd_total - rd_base;
            ax_dout  <= {bl_tab[(fidx >> 5) > 3 ? 3 : (fidx >> 5)], 8'(fidx)};
            rd_total <= rd_total + 1;
        end
    end

    // Monitor: pops and compares expectations away from the active edge.
    always @(negedge clk) begin
        stat_t s;
        int    d;
        if (ax_rd_en || (exp_rd_q.size() > 0 && exp_rd_q[0] == cyc)) begin
            n_chk++;
            if (ax_rd_en && exp_rd_q.size() > 0 && exp_rd_q[0] == cyc) begin
                d = exp_rd_q.pop_front();
            end else if (ax_rd_en) begin
                n_fail++;
                $display("FAIL rd_extra cycle %0d: ax_rd_en got 1 required 0", cyc);
            end else begin
                n_fail++;
                d = exp_rd_q.pop_front();
                $display("FAIL rd_missing cycle %0d: ax_rd_en got 0 required 1", cyc);
            end
        end
        if (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            s = stat_q.pop_front();
            n_chk++;
            if ({ax_rd_en, burst_active, burst_cnt, underrun, audio_on} !== {s.rd, s.act, s.bcnt, s.und, s.aon}) begin
                n_fail++;
                $display("FAIL stat#%0d cycle %0d: got rd=%b act=%b bcnt=%0d und=%b aon=%b required rd=%b act=%b bcnt=%0d und=%b aon=%b",
                         s.tag, cyc, ax_rd_en, burst_active, burst_cnt, underrun, audio_on,
                         s.rd, s.act, s.bcnt, s.und, s.aon);
            end
`ifdef AUDIO_SCHED_STATS_EN
            if (s.chkw) begin
                n_chk++;
                if (rd_words !== s.w) begin
                    n_fail++;
                    $display("FAIL rd_words#%0d cycle %0d: got %0d required %0d", s.tag, cyc, rd_words, s.w);
                end
            end
`endif
        end
        if (done && !flushed) begin
            flushed = 1'b1;
            foreach (exp_rd_q[i]) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_never_seen: expected read at cycle %0d never checked", exp_rd_q[i]);
            end
            foreach (stat_q[i]) begin
                n_chk++;
                n_fail++;
                $display("FAIL stat_never_seen: stat#%0d at cycle %0d never checked", stat_q[i].tag, stat_q[i].cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rd(input int first, input int n);
        for (int i = 0; i < n; i++) exp_rd_q.push_back(first + i);
    endtask

    task automatic exp_st(input int at, input int tag, input int rd, input int act, input int bcnt,
                          input int und, input int aon, input int chkw, input int w);
        stat_t s;
        s.cyc  = at;
        s.tag  = tag;
        s.rd   = rd[0];
        s.act  = act[0];
        s.bcnt = bcnt[3:0];
        s.und  = und[0];
        s.aon  = aon[0];
        s.chkw = chkw[0];
        s.w    = w[15:0];
        stat_q.push_back(s);
    endtask

    task automatic set_bl(input int a, input int b, input int d, input int e);
        bl_tab[0] = a[3:0];
        bl_tab[1] = b[3:0];
        bl_tab[2] = d[3:0];
        bl_tab[3] = e[3:0];
    endtask

    task automatic boundary();
        vcnt = 12'd0;
        hcnt = 12'd0;
        step(1);
        vcnt = 12'd5;
        hcnt = 12'd1531;
    endtask

    initial begin
        sys_rst  = 1'b1;
        hcnt     = 12'd100;
        vcnt     = 12'd5;
        vde      = 1'b0;
        ax_empty = 1'b1;
        set_bl(0, 0, 0, 0);
        step(3);

        // Reset state
        c = cyc;
        exp_st(c, 1, 0, 0, 0, 0, 0, 1, 0);
        sys_rst = 1'b0;
        step(1);

        // Audio before video: no burst without init
        ax_empty = 1'b0;
        step(1);
        c = cyc;
        hcnt = HS;
        exp_st(c + 1, 2, 0, 0, 0, 0, 0, 0, 0);
        exp_st(c + 3, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(4);
        vde = 1'b1;
        step(1);
        vde = 1'b0;
        step(2);

        // Single burst
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 32);
        exp_st(c + 1, 4, 1, 1, 1, 0, 0, 0, 0);
        exp_st(c + 32, 5, 1, 1, 1, 0, 0, 0, 0);
        exp_st(c + 33, 6, 0, 1, 1, 0, 0, 0, 0);
        exp_st(c + 36, 7, 0, 1, 1, 0, 0, 0, 0);
        exp_st(c + 37, 8, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(40);

        // Three bursts: b_left 2,1,0
        set_bl(2, 1, 0, 0);
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 32);
        exp_rd(c + 37, 32);
        exp_rd(c + 73, 32);
        exp_st(c + 1, 9, 1, 1, 1, 0, 0, 0, 0);
        exp_st(c + 36, 10, 0, 1, 1, 0, 0, 0, 0);
        exp_st(c + 37, 11, 1, 1, 2, 0, 0, 0, 0);
        exp_st(c + 73, 12, 1, 1, 3, 0, 0, 0, 0);
        exp_st(c + 104, 13, 1, 1, 3, 0, 0, 0, 0);
        exp_st(c + 105, 14, 0, 1, 3, 0, 0, 0, 0);
        exp_st(c + 109, 15, 0, 0, 3, 0, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(112);

        // Underrun: ax_empty at burst cycles 10..14
        set_bl(0, 0, 0, 0);
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 10);
        exp_rd(c + 16, 17);
        exp_st(c + 1, 16, 1, 1, 1, 0, 0, 0, 0);
        exp_st(c + 11, 17, 0, 1, 1, 0, 0, 0, 0);
        exp_st(c + 12, 18, 0, 1, 1, 1, 0, 0, 0);
        exp_st(c + 32, 19, 1, 1, 1, 1, 0, 0, 0);
        exp_st(c + 37, 20, 0, 0, 1, 1, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(10);
        ax_empty = 1'b1;
        step(5);
        ax_empty = 1'b0;
        step(25);

        // vde abort in GAP cycle 2; a second burst would otherwise follow
        set_bl(1, 0, 0, 0);
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 32);
        exp_st(c + 35, 21, 0, 1, 1, 1, 0, 0, 0);
        exp_st(c + 36, 22, 0, 0, 1, 1, 0, 0, 0);
        exp_st(c + 40, 23, 0, 0, 1, 1, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(34);
        vde = 1'b1;
        step(1);
        vde = 1'b0;
        step(8);

        // vde abort in BURST cycle 5 gates ax_rd_en the same cycle
        set_bl(0, 0, 0, 0);
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 5);
        exp_st(c + 6, 24, 0, 1, 1, 1, 0, 0, 0);
        exp_st(c + 7, 25, 0, 0, 1, 1, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(5);
        vde = 1'b1;
        step(1);
        vde = 1'b0;
        step(5);

        // Frame boundaries: presence, underrun clear, read statistics (192 reads so far)
        ax_empty = 1'b1;
        step(1);
        c = cyc;
        exp_st(c + 1, 26, 0, 0, 1, 0, 1, 1, 192);
        boundary();
        step(5);
        c = cyc;
        exp_st(c + 1, 27, 0, 0, 1, 0, 0, 1, 0);
        boundary();
        step(3);
        ax_empty = 1'b0;
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 32);
        exp_st(c + 40, 28, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(41);
        c = cyc;
        exp_st(c + 1, 29, 0, 0, 1, 0, 1, 1, 32);
        boundary();
        ax_empty = 1'b1;
        step(5);
        // ck was set in the previous boundary cycle itself, so audio stays on
        c = cyc;
        exp_st(c + 1, 30, 0, 0, 1, 0, 1, 1, 0);
        boundary();
        step(3);

        // Reset mid-burst, then init must be cleared
        ax_empty = 1'b0;
        c = cyc;
        hcnt = HS;
        rd_base = rd_total;
        exp_rd(c + 1, 10);
        exp_st(c + 11, 31, 0, 0, 0, 0, 0, 1, 0);
        step(1);
        hcnt = 12'd1531;
        step(9);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        step(2);
        c = cyc;
        hcnt = HS;
        exp_st(c + 1, 32, 0, 0, 0, 0, 0, 0, 0);
        exp_st(c + 3, 33, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        hcnt = 12'd1531;
        step(4);

        done = 1'b1;
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
